// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, synchronous flush and one-cycle overflow/underflow pulses.
//
// Optional build macro: SYNC_FIFO_FWFT_EN
//   undefined : registered-read mode. A read accepted on an edge loads the head
//               entry into data_out on that edge (1-cycle latency).
//   defined   : first-word fall-through. data_out shows the head entry whenever
//               the FIFO is non-empty. r_en pops the head.
//
// Handshake: a write is accepted on a rising edge when w_en=1 and full=0. A read
// is accepted when r_en=1 and empty=0. Both flags are the registered values from
// before the edge. flush overrides both requests.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   w_en         in   write request
//   r_en         in   read request / pop (FWFT)
//   flush        in   synchronous clear of contents
//   data_in      in   [DATA_WIDTH-1:0] write data
//   data_out     out  [DATA_WIDTH-1:0] read data
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  [$clog2(DEPTH):0] occupancy, 0..DEPTH
//   overflow     out  pulse: write rejected because full
//   underflow    out  pulse: read rejected because empty
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the registered flags, so a simultaneous read cannot
    // make room for a write in the same edge (and vice versa).
    assign wr_acc = w_en & ~full_q  & ~flush;
    assign rd_acc = r_en & ~empty_q & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Flags come from the next-state count so they line up with count.
    always_comb begin
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = w_en & full_q  & ~flush;
        unf_d   = r_en & empty_q & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // hold_q tracks whatever is on display while non-empty, so data_out keeps
    // its last value after the final pop or after a flush.
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (!empty_q) begin
            hold_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = empty_q ? hold_q : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out = dout_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed bench for sync_fifo_param (DEPTH=16, DATA_WIDTH=8, AF=14, AE=2).
// A queue-based model tracks the expected contents; a compare process checks
// every DUT output against it on each falling edge. Literal checks pin key
// points of the scenarios. Honours SYNC_FIFO_FWFT_EN in the model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          w_en    = 1'b0;
    logic          r_en    = 1'b0;
    logic          flush   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [$clog2(DEPTH):0] count;

    sync_fifo_param #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_en        (w_en),
        .r_en        (r_en),
        .flush       (flush),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // scoreboard / model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dout = '0;
    bit            exp_ovf  = 1'b0;
    bit            exp_unf  = 1'b0;
    bit            check_en = 1'b0;
    int            n_checks = 0;
    int            n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // Queue semantics: occupancy before the edge decides what is accepted.
    task automatic model_update(input bit w, input bit r, input bit f, input logic [DW-1:0] d);
        int n;
        n = exp_q.size();
        if (f) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = w && (n == DEPTH);
            exp_unf = r && (n == 0);
            if (r && n > 0) exp_dout = exp_q.pop_front();
            if (w && n < DEPTH) exp_q.push_back(d);
        end
`ifdef SYNC_FIFO_FWFT_EN
        if (exp_q.size() > 0) exp_dout = exp_q[0];
`endif
    endtask

    // compare process
    always @(negedge clk) begin
        if (check_en) begin
            check("data_out",     32'(data_out),     32'(exp_dout));
            check("count",        32'(count),        exp_q.size());
            check("full",         32'(full),         32'(exp_q.size() == DEPTH));
            check("empty",        32'(empty),        32'(exp_q.size() == 0));
            check("almost_full",  32'(almost_full),  32'(exp_q.size() >= AF));
            check("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
            check("overflow",     32'(overflow),     32'(exp_ovf));
            check("underflow",    32'(underflow),    32'(exp_unf));
        end
    end

    // driver: one clock cycle with the given request inputs
    task automatic step(input bit w, input bit r, input bit f, input logic [DW-1:0] d);
        w_en    = w;
        r_en    = r;
        flush   = f;
        data_in = d;
        @(posedge clk);
        if (rst_n) model_update(w, r, f, d);
        @(negedge clk);
        #1;
        w_en  = 1'b0;
        r_en  = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        // reset then idle
        #1 rst_n = 1'b0;
        model_reset();
        check_en = 1'b1;
        repeat (10) step(1'b0, 1'b0, 1'b0, '0);
        check("rst_empty",    32'(empty),        32'd1);
        check("rst_full",     32'(full),         32'd0);
        check("rst_count",    32'(count),        32'd0);
        check("rst_data_out", 32'(data_out),     32'd0);
        check("rst_ae",       32'(almost_empty), 32'd1);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);

        // fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'(i));
            if (i == 12) check("af_before_14", 32'(almost_full), 32'd0);
            if (i == 13) check("af_after_14",  32'(almost_full), 32'd1);
        end
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd16);
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd16);
        step(1'b0, 1'b0, 1'b0, '0);
        check("ovf_clear", 32'(overflow), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_head", 32'(data_out), 32'h00);
`endif

        // drain in order, then one rejected read
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);
        check("drain_last",  32'(data_out), 32'h0F);
        check("drain_empty", 32'(empty),    32'd1);
        step(1'b0, 1'b1, 1'b0, '0);
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_hold",  32'(data_out),  32'h0F);

        // wrap with simultaneous access
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++)  step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, DW'($urandom_range(0, 255)));
        check("wrap_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);

        // full with simultaneous write/read
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h10 + i));
        step(1'b1, 1'b1, 1'b0, 8'h55);
        check("fullrw_count", 32'(count),    32'd15);
        check("fullrw_ovf",   32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 1'b0, '0);

        // empty with simultaneous write/read
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        check("emptyrw_count", 32'(count),     32'd1);
        check("emptyrw_unf",   32'(underflow), 32'd1);
        step(1'b0, 1'b1, 1'b0, '0);

        // flush with a concurrent write
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'(8'hA0 + i));
        step(1'b1, 1'b0, 1'b1, 8'h77);
        check("flush_count", 32'(count),     32'd0);
        check("flush_empty", 32'(empty),     32'd1);
        check("flush_ovf",   32'(overflow),  32'd0);
        check("flush_unf",   32'(underflow), 32'd0);

        // refill, then asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, DW'(8'hB0 + i));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_count",    32'(count),        32'd0);
        check("arst_empty",    32'(empty),        32'd1);
        check("arst_full",     32'(full),         32'd0);
        check("arst_data_out", 32'(data_out),     32'd0);
        check("arst_ae",       32'(almost_empty), 32'd1);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // first write after reset comes back out
        step(1'b1, 1'b0, 1'b0, 8'hC3);
        step(1'b0, 1'b1, 1'b0, '0);
        check("post_rst_data", 32'(data_out), 32'hC3);
        step(1'b0, 1'b0, 1'b0, '0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's 8-bit FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, a synchronous flush, and overflow/underflow error pulses.
- Sits between a producer and a consumer in one clock domain, as a general-purpose buffer for datapath blocks.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- w_en  input  1  write request
- r_en  input  1  read request
- flush  input  1  synchronous clear of contents
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write rejected because full
- underflow  output  1  one-cycle pulse: read rejected because empty

Behaviour:
- Reset (rst_n=0, asynchronous): write pointer, read pointer and count = 0; data_out = 0; empty=1; full=0; almost_empty=1; almost_full=0; overflow=0; underflow=0. Storage contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Occupancy is held in the count register, not derived from pointer comparison.
- Write accepted on a rising edge when w_en=1 and full=0. data_in is stored at the write pointer, and the write pointer increments.
- Read accepted on a rising edge when r_en=1 and empty=0. The entry at the read pointer is registered into data_out on that edge (1-cycle latency), and the read pointer increments. data_out holds its value when no read is accepted.
- full and empty gate their respective operations strictly, using registered flags from before the edge:
  - w_en and r_en both high while full: read accepted, write rejected; overflow pulses; count becomes DEPTH-1.
  - w_en and r_en both high while empty: write accepted, read rejected; underflow pulses; count becomes 1; data_out unchanged.
  - Both accepted (0<count<DEPTH): count unchanged; both pointers advance.
- count update: +1 on write only; -1 on read only; unchanged when both or neither are accepted.
- All status flags (full, empty, almost_full, almost_empty) are registered and derived from the next-state count, so they are valid in the same cycle as count.
- overflow = 1 for exactly the cycle after an edge with w_en & full; underflow likewise for r_en & empty. No sticky state.
- flush=1 has priority over w_en and r_en:
  - pointers and count cleared to 0; empty=1, full=0;
  - data_out unchanged;
  - no error pulses in that cycle.
- Asserting rst_n mid-operation discards all contents immediately. The first write after release lands at entry 0.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN
- Defined (first-word fall-through):
  - data_out continuously shows the head entry whenever empty=0;
  - r_en acknowledges and pops the head, so the next entry appears the cycle after the pop edge;
  - when empty, data_out holds its last value;
  - flags and count behave as above.
  - A write into an empty FIFO makes the word visible on data_out one cycle after the write edge.
- Undefined: standard registered-read mode as described in Behaviour.

Test Plan:
- Reset then idle: hold rst_n=0 for 10 cycles -> empty=1, full=0, count=0, data_out=0, almost_empty=1.
- Fill to full (DEPTH=16, AF_THRESH=14): write 0x00..0x0F on consecutive cycles -> almost_full rises after the 14th write, full=1 and count=16 after the 16th. A 17th write of 0xAA -> overflow pulses 1 cycle; count stays 16.
- Drain in order: read 16 times -> data_out = 0x00..0x0F, each 1 cycle after its read edge; empty=1 after the last read. A further read -> underflow pulses; data_out stays 0x0F.
- Wrap and simultaneous access: write 10 words, read 6, then 40 cycles of simultaneous w_en/r_en with random data -> every word read matches a scoreboard queue, count stays 4, pointers wrap at least twice.
- Full + simultaneous: fill to 16, then assert w_en=r_en with data 0x55 -> count=15, overflow=1, 0x55 is never read back.
- Flush and reset mid-operation: with 5 entries, pulse flush together with w_en=1 -> count=0, empty=1, no pulses. Refill 3 entries, drop rst_n asynchronously mid-cycle -> outputs reach reset values before the next edge. With SYNC_FIFO_FWFT_EN defined, rerun the drain scenario: data_out=0x00 before any r_en.
